// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared encodings for the shift-register serial link
package serial_pkg;

    // Receiver framing states: hunting for a start marker, or collecting word bits.
    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    // Bit order on the wire, common to transmitter and receiver.
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_bit_counter.sv
// rtl/serial_bit_counter.sv - per-word bit counter with wrap flag at the last bit
module serial_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == CNT_W'(WIDTH - 1));

    // Next count: a start bit always lands on 1, the last bit of a word wraps to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register; clear has priority over any update.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - serial-in/parallel-out receiver with one-word holding buffer
module serial_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_first,
    input  logic             dir,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             frame_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
    logic             cnt_load1;
    logic             cnt_inc;
    logic             word_done;

    serial_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .clr_i   (~rst),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt),
        .wrap_o  (cnt_wrap)
    );

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

    // Framing, shifting and holding-buffer decisions for the coming edge.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        dir_d        = dir_q;
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = 1'b0;
        frame_err_d  = 1'b0;
        cnt_load1    = 1'b0;
        cnt_inc      = 1'b0;
        word_done    = 1'b0;

        if (sin_valid) begin
            if (sin_first) begin
                // A start marker always begins a fresh word; any partial word is thrown away.
                cnt_load1 = 1'b1;
                dir_d     = dir;
                state_d   = ST_COLLECT;
                if ((state_q == ST_COLLECT) && (cnt != '0)) begin
                    frame_err_d = 1'b1;
                end
                if (dir == DIR_MSB_FIRST) begin
                    sr_d = {{(WIDTH-1){1'b0}}, sin};
                end else begin
                    sr_d = {sin, {(WIDTH-1){1'b0}}};
                end
            end else if (state_q == ST_COLLECT) begin
                // Ordinary data bit: order follows the direction latched at the word start.
                cnt_inc = 1'b1;
                if (dir_q == DIR_MSB_FIRST) begin
                    sr_d = {sr_q[WIDTH-2:0], sin};
                end else begin
                    sr_d = {sin, sr_q[WIDTH-1:1]};
                end
                word_done = cnt_wrap;
            end
        end

        // Buffer accepts a new word when empty or being drained this same edge.
        if (word_done) begin
            if (!pout_valid_q || pout_ready) begin
                pout_d       = sr_d;
                pout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pout_valid_q && pout_ready) begin
            pout_valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            dir_q        <= DIR_MSB_FIRST;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            dir_q        <= dir_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
